wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-side register file for the single-issue RV64 core. It consumes the ALU writeback triple (destination index, write enable, result) through a one-entry commit stage and holds the 32 architectural integer registers. It serves two combinational read ports to ID and one debug read port for difftest. An optional bypass network returns in-flight results to ID before they reach the array.

## Interface
Parameters:
- XLEN, 64, register width; equals `RegBus` width.
- NREG, 32, architectural register count; index width is 5 (`RegAddrBus`).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset, synchronous, active-low.
- wb_valid_i, input, 1, writeback triple valid this cycle.
- wb_we_i, input, 1, write-enable from ALU (`wreg_o`).
- wb_waddr_i, input, 5, destination index from ALU (`wd_o`).
- wb_wdata_i, input, XLEN, result from ALU (`wdata_o`).
- re1_i, input, 1, read port 1 enable.
- raddr1_i, input, 5, read port 1 index.
- rdata1_o, output, XLEN, read port 1 data, combinational.
- re2_i, input, 1, read port 2 enable.
- raddr2_i, input, 5, read port 2 index.
- rdata2_o, output, XLEN, read port 2 data, combinational.
- dbg_raddr_i, input, 5, difftest read index.
- dbg_rdata_o, output, XLEN, array contents only, never bypassed.
- pend_o, output, 1, commit stage holds a write not yet in the array.
- commit_cnt_o, output, 64, number of writes committed to the array since reset.

## Operation
- Accept condition: wb_valid_i & wb_we_i & (wb_waddr_i != 0). Writes to x0 are discarded and are never counted.
- Commit stage registers: pend_v, pend_a[4:0], pend_d[XLEN-1:0].
  - Each edge: pend_v <= accept.
  - Address and data are loaded only when accept is 1.
- Array update, each edge: if pend_v, then arr[pend_a] <= pend_d and commit_cnt increments by 1, wrapping modulo 2^64.
- A stage load and an array commit on the same edge are legal and independent. Back-to-back writes to the same index commit in order, and the later write wins.
- Read data per port p:
  - rdata = 0 if !re_p, or if raddr_p == 0, or if rst_n == 0.
  - Otherwise rdata is the highest-priority source from the Configuration section.
- x0 reads as 0 on every port, including the debug port. arr[0] is never written.
- pend_o = pend_v.

## Timing
- Reset (edge with rst_n = 0):
  - All arr entries become 0; pend_v = 0; pend_a = 0; pend_d = 0; commit_cnt = 0.
  - rdata1_o, rdata2_o and dbg_rdata_o are 0 while rst_n is low.
- Reset mid-operation: a pending write is dropped and never reaches the array. A write presented on the reset edge is ignored.
- Write latency to the array: 2 edges. The triple is presented in cycle N, enters the stage at edge N+1, and is in the array at edge N+2. dbg_rdata_o reflects it from cycle N+2.
- Read ports: zero-latency combinational paths with no handshake.
- commit_cnt_o updates on the same edge the array is written.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: read source priority is:
  1. The live input, when accept is 1 and wb_waddr_i == raddr.
  2. The stage, when pend_v is 1 and pend_a == raddr.
  3. arr[raddr].
  - A written value is therefore visible to ID in the same cycle it is presented.
- Not defined: reads return arr[raddr] only, so ID sees the new value 2 edges after presentation. The stage logic and the array logic are identical in both builds.

## Test plan
- Reset then read: hold rst_n=0 for 2 cycles, then release. Read all 32 indices on both ports -> all 0; commit_cnt_o=0; pend_o=0.
- Basic write: present x5=0x1234 with valid=1, we=1 for one cycle.
  - pend_o=1 in the next cycle.
  - dbg_rdata_o(5)=0x1234 two edges after presentation; commit_cnt_o=1.
- x0 and disabled writes:
  - Write x0=0xDEAD -> x0 still reads 0, pend_o stays 0, commit_cnt_o unchanged.
  - Write x7=0x55 with we=0 -> x7 stays 0.
- Back-to-back same index: x3=0xA, then x3=0xB in consecutive cycles -> final array x3=0xB; commit_cnt_o advances by 2.
- Bypass, with REGFILE_BYPASS_EN defined: present x9=0x77 while raddr1_i=9 and re1_i=1 -> rdata1_o=0x77 in the same cycle and the next cycle.
  - Without the macro, rdata1_o stays 0 until two edges after presentation.
- Reset mid-write: present x4=0x99, then assert rst_n=0 on the following edge -> x4 reads 0 after reset; commit_cnt_o=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback register file: one-entry commit stage feeding a 32 x XLEN array, two ID read ports and a debug port.
// Optional read bypass of in-flight writes is enabled with REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_waddr_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic            re1_i,
    input  logic [4:0]      raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic            re2_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic [4:0]      dbg_raddr_i,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic            pend_o,
    output logic [63:0]     commit_cnt_o
);

    logic [XLEN-1:0] arr [NREG];
    logic            pend_v;
    logic [4:0]      pend_a;
    logic [XLEN-1:0] pend_d;
    logic [63:0]     commit_cnt;
    logic            accept;

    // x0 writes are dropped here, so pend_a is never 0 and arr[0] stays zero.
    assign accept = wb_valid_i & wb_we_i & (wb_waddr_i != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_v     <= 1'b0;
            pend_a     <= '0;
            pend_d     <= '0;
            commit_cnt <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                arr[i] <= '0;
            end
        end else begin
            pend_v <= accept;
            if (accept) begin
                pend_a <= wb_waddr_i;
                pend_d <= wb_wdata_i;
            end
            if (pend_v) begin
                arr[pend_a] <= pend_d;
                commit_cnt  <= commit_cnt + 64'd1;
            end
        end
    end

    always_comb begin
        rdata1_o = '0;
        if (rst_n && re1_i && (raddr1_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (accept && (wb_waddr_i == raddr1_i)) begin
                rdata1_o = wb_wdata_i;
            end else if (pend_v && (pend_a == raddr1_i)) begin
                rdata1_o = pend_d;
            end else begin
                rdata1_o = arr[raddr1_i];
            end
`else
            rdata1_o = arr[raddr1_i];
`endif
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (rst_n && re2_i && (raddr2_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (accept && (wb_waddr_i == raddr2_i)) begin
                rdata2_o = wb_wdata_i;
            end else if (pend_v && (pend_a == raddr2_i)) begin
                rdata2_o = pend_d;
            end else begin
                rdata2_o = arr[raddr2_i];
            end
`else
            rdata2_o = arr[raddr2_i];
`endif
        end
    end

    // Debug port shows committed array state only.
    always_comb begin
        dbg_rdata_o = '0;
        if (rst_n && (dbg_raddr_i != '0)) begin
            dbg_rdata_o = arr[dbg_raddr_i];
        end
    end

    assign pend_o       = pend_v;
    assign commit_cnt_o = commit_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected outputs per cycle, monitor pops and compares on negedge.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid_i, wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [63:0] wb_wdata_i;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i, dbg_raddr_i;
    logic [63:0] rdata1_o, rdata2_o, dbg_rdata_o, commit_cnt_o;
    logic        pend_o;

    wb_regfile #(.XLEN(64), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i),
        .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
        .dbg_raddr_i(dbg_raddr_i), .dbg_rdata_o(dbg_rdata_o),
        .pend_o(pend_o), .commit_cnt_o(commit_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r1, r2, dbg, cnt;
        logic        pend;
    } exp_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
        int          at;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         infl[$];
    logic [63:0] arr_m [32];
    logic [63:0] cnt_m;
    int          edge_n;
    int          n_checks = 0;
    int          n_pass   = 0;

    // Model: each accepted write lands in the array on the second edge after it is presented.
    task automatic model_edge(input logic rst, input logic acc, input logic [4:0] wa, input logic [63:0] wd);
        edge_n++;
        if (!rst) begin
            for (int i = 0; i < 32; i++) arr_m[i] = '0;
            infl.delete();
            cnt_m = '0;
        end else begin
            while (infl.size() != 0 && infl[0].at == edge_n) begin
                wr_t w;
                w = infl.pop_front();
                arr_m[w.a] = w.d;
                cnt_m++;
            end
            if (acc) begin
                wr_t n;
                n.a = wa; n.d = wd; n.at = edge_n + 1;
                infl.push_back(n);
            end
        end
    endtask

    function automatic logic [63:0] model_read(input logic rst, input logic re, input logic [4:0] a,
                                               input logic acc, input logic [4:0] wa, input logic [63:0] wd);
        if (!rst || !re || a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (acc && wa == a) return wd;
        for (int i = infl.size() - 1; i >= 0; i--)
            if (infl[i].a == a) return infl[i].d;
`endif
        return arr_m[a];
    endfunction

    task automatic cyc(input logic rst, input logic v, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2, input logic [4:0] da);
        exp_t e;
        logic acc;
        rst_n = rst; wb_valid_i = v; wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd;
        re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2; dbg_raddr_i = da;
        acc    = v & we & (wa != 5'd0);
        e.r1   = model_read(rst, r1, a1, acc, wa, wd);
        e.r2   = model_read(rst, r2, a2, acc, wa, wd);
        e.dbg  = (rst && da != 5'd0) ? arr_m[da] : 64'd0;
        e.pend = (infl.size() != 0);
        e.cnt  = cnt_m;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(rst, acc, wa, wd);
        #1;
    endtask

    task automatic idle(input logic [4:0] a);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, a, 1'b1, a, a);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [63:0] wd, input logic we);
        cyc(1'b1, 1'b1, we, wa, wd, 1'b1, wa, 1'b1, wa, wa);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rdata1", rdata1_o, e.r1);
                chk("rdata2", rdata2_o, e.r2);
                chk("dbg_rdata", dbg_rdata_o, e.dbg);
                chk("pend", {63'd0, pend_o}, {63'd0, e.pend});
                chk("commit_cnt", commit_cnt_o, e.cnt);
            end
        end
    end

    initial begin : driver
        edge_n = 0;
        cnt_m  = '0;
        for (int i = 0; i < 32; i++) arr_m[i] = '0;
        rst_n = 1'b0; wb_valid_i = 1'b0; wb_we_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
        re1_i = 1'b0; re2_i = 1'b0; raddr1_i = '0; raddr2_i = '0; dbg_raddr_i = '0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        cyc(1'b0, 1'b1, 1'b1, 5'd6, 64'hFFFF, 1'b1, 5'd6, 1'b1, 5'd1, 5'd6);

        for (int i = 0; i < 32; i++)
            cyc(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i), 5'(i));

        wr(5'd5, 64'h1234, 1'b1);
        repeat (3) idle(5'd5);

        wr(5'd0, 64'hDEAD, 1'b1);
        idle(5'd0);
        wr(5'd7, 64'h55, 1'b0);
        repeat (3) idle(5'd7);

        wr(5'd3, 64'hA, 1'b1);
        wr(5'd3, 64'hB, 1'b1);
        repeat (3) idle(5'd3);

        wr(5'd9, 64'h77, 1'b1);
        repeat (3) idle(5'd9);

        wr(5'd4, 64'h99, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4);
        repeat (3) idle(5'd4);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, a1, a2;
            logic rst;
            rst = ($urandom_range(0, 49) != 0);
            wa  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 7));
            a2  = 5'($urandom_range(0, 7));
            cyc(rst, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), wa, {$urandom, $urandom},
                1'($urandom_range(0, 7) != 0), a1, 1'($urandom_range(0, 7) != 0), a2, 5'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
